hazard_match_pipe: RTL and testbench
====================================

// Module: hazard_match_pipe
// PURPOSE
//  Tracks register addresses and hazard-relevant control bits through the D->E->M->W pipeline.
//  Produces the register-match, RegWrite/MemtoReg and PC-write-pending signals consumed by the
//  hazard unit in the same cycle.
//  Sits between the decode stage and the hazard unit. Consumes the hazard unit's FlushE, so that
//  flushed instructions stop producing matches.
// PARAMETERS
//  REG_AW  4   register address width
//  PC_REG  15  address of the PC register; reads of it are never matched or forwarded
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  RA1D          in   REG_AW  decode-stage source register 1
//  RA2D          in   REG_AW  decode-stage source register 2
//  WA3D          in   REG_AW  decode-stage destination register
//  RegWriteD     in   1       decode instr writes register file
//  MemtoRegD     in   1       decode instr is a load
//  PCSrcD        in   1       decode instr writes PC (branch or Rd==PC_REG)
//  CondExE       in   1       execute-stage condition passed
//  FlushE        in   1       from hazard unit: bubble the D->E register
//  Match_1E_M    out  1       RA1E == WA3M
//  Match_1E_W    out  1       RA1E == WA3W
//  Match_2E_M    out  1       RA2E == WA3M
//  Match_2E_W    out  1       RA2E == WA3W
//  Match_12D_E   out  1       RA1D == WA3E or RA2D == WA3E
//  MemtoRegE     out  1       E-stage load flag (registered)
//  RegWriteM     out  1       M-stage write enable (condition-gated)
//  RegWriteW     out  1       W-stage write enable
//  PCWrPendingF  out  1       PC write in D, E or M stage
//  PCSrcW        out  1       W-stage PC write
// BEHAVIOUR
//  Reset state
//  - All stage registers (addresses and control) clear to 0 on reset.
//  - Consequence: every output is 0 in the cycle after reset is sampled.
//  D->E register
//  - Captures RA1/RA2/WA3/RegWrite/MemtoReg/PCSrc every cycle.
//  - If FlushE=1, control bits are cleared to 0 and addresses are cleared to 0; no enable.
//  - StallD is not an input; a stalled D simply re-presents the same inputs.
//  E->M register
//  - WA3M <= WA3E.
//  - RegWriteM <= RegWriteE & CondExE.
//  - PCSrcM <= PCSrcE & CondExE.
//  M->W register: pure copy. No stalls or flushes are applied to E->M or M->W.
//  Matches (combinational from registered state)
//  - A match is forced to 0 when the compared source address == PC_REG.
//  - Matches are raw address compares; write-enable gating is done in the hazard unit, not here.
//  - Match_12D_E uses the live RA1D/RA2D against the registered WA3E.
//  PCWrPendingF (combinational) = PCSrcD | PCSrcE | PCSrcM.
//  - PCSrcE here is the raw registered bit; PCSrcM is already condition-gated.
//  Latency
//  - Decode inputs reach the E compare 1 cycle later, M 2 cycles later, W 3 cycles later.
//  Simultaneous events
//  - FlushE together with a new D instruction: the D instruction is dropped from E.
//  - The D-stage compare (Match_12D_E) is unaffected in that cycle.
//  Reset mid-operation: all in-flight stages are squashed in the same edge.
//  Any X on CondExE while RegWriteE=0 must not propagate to RegWriteM.
// STRUCTURE
//  hazard_pkg holds:
//  - REG_AW and PC_REG localparams.
//  - typedef stage_ctl_t {RegWrite, MemtoReg, PCSrc}.
//  - typedef reg_addr_t.
//  Sub-module: stage_reg_clr (parameterised width, synchronous clear), instantiated 3x.
// TESTING
//  1. Reset: hold reset 2 cycles with random inputs -> all outputs 0 on the cycle after reset drops.
//  2. EX forward: D1 WA3D=3 RegWrite=1, next D2 RA1D=3.
//     -> Match_1E_M=1 and RegWriteM=1 when D2 reaches E; next cycle Match_1E_W=1.
//  3. Load-use: D1 MemtoReg=1 WA3D=5, next D2 RA2D=5 -> Match_12D_E=1 with MemtoRegE=1.
//     Assert FlushE -> next cycle MemtoRegE=0.
//  4. Condition fail: RegWriteD=1 WA3D=2, CondExE=0 in E -> RegWriteM=0 and RegWriteW=0.
//     Match_1E_M still 1 if RA1E=2.
//  5. PC write: PCSrcD=1 one cycle, CondExE=1 -> PCWrPendingF=1 for 3 cycles, PCSrcW=1 on 4th.
//  6. PC source: RA1D=15 with WA3 of prior instr=15 -> no match asserted in any stage.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, register-file constants and stage-register
// payload types for the hazard-tracking pipeline.
//   REG_AW      register address width
//   PC_REG      address of the PC register (never matched)
//   reg_addr_t  register address
//   stage_ctl_t hazard-relevant control bits carried D->E
//   de_t        D->E stage payload
//   ew_t        E->M and M->W stage payload
package hazard_pkg;

  localparam int REG_AW = 4;
  localparam int PC_REG = 15;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic pc_src;
  } stage_ctl_t;

  // valid is set for every captured instruction and cleared by reset or
  // flush, so bubbles and the post-reset state never report a match.
  typedef struct packed {
    logic       valid;
    reg_addr_t  ra1;
    reg_addr_t  ra2;
    reg_addr_t  wa3;
    stage_ctl_t ctl;
  } de_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t wa3;
    logic      reg_write;
    logic      pc_src;
  } ew_t;

  // Raw address compare; a read of the PC register is never a hazard.
  function automatic logic src_match(input reg_addr_t src, input reg_addr_t dst);
    return (src != reg_addr_t'(PC_REG)) && (src == dst);
  endfunction

endpackage

// File: rtl/stage_reg_clr.sv
// stage_reg_clr: W-bit pipeline register, loads every cycle, with a
// synchronous clear that forces a bubble.
//   clk    clock, rising edge
//   reset  synchronous, active-high; clears the register
//   clr    synchronous clear (bubble insert)
//   d      next-stage data in
//   q      registered data out
module stage_reg_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // NOTE: assign the default first so every path writes q_d; otherwise a
  // latch is inferred.
  always_comb begin
    q_d = d;
    if (clr) q_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all stage
  // registers update together on the edge regardless of process order.
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_match_pipe.sv
// hazard_match_pipe: carries register addresses and hazard control bits
// through D->E->M->W and produces the same-cycle compare/status signals
// used by the hazard unit.
//   clk, reset            clock; synchronous active-high reset
//   RA1D/RA2D/WA3D        decode source/destination register addresses
//   RegWriteD/MemtoRegD   decode write-enable and load flags
//   PCSrcD                decode instruction writes the PC
//   CondExE               execute-stage condition passed
//   FlushE                bubble the D->E register
//   Match_*               source/destination address compares
//   MemtoRegE             E-stage load flag
//   RegWriteM/RegWriteW   M/W write enables (M is condition-gated)
//   PCWrPendingF          PC write somewhere in D, E or M
//   PCSrcW                W-stage PC write
module hazard_match_pipe
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t RA1D,
  input  reg_addr_t RA2D,
  input  reg_addr_t WA3D,
  input  logic      RegWriteD,
  input  logic      MemtoRegD,
  input  logic      PCSrcD,
  input  logic      CondExE,
  input  logic      FlushE,
  output logic      Match_1E_M,
  output logic      Match_1E_W,
  output logic      Match_2E_M,
  output logic      Match_2E_W,
  output logic      Match_12D_E,
  output logic      MemtoRegE,
  output logic      RegWriteM,
  output logic      RegWriteW,
  output logic      PCWrPendingF,
  output logic      PCSrcW
);

  de_t de_d, de_q;
  ew_t em_d, em_q;
  ew_t mw_q;

  always_comb begin
    de_d.valid          = 1'b1;
    de_d.ra1            = RA1D;
    de_d.ra2            = RA2D;
    de_d.wa3            = WA3D;
    de_d.ctl.reg_write  = RegWriteD;
    de_d.ctl.mem_to_reg = MemtoRegD;
    de_d.ctl.pc_src     = PCSrcD;

    // AND with a known 0 resolves to 0, so an unknown CondExE cannot leak
    // into M when E does not write.
    em_d.valid     = de_q.valid;
    em_d.wa3       = de_q.wa3;
    em_d.reg_write = de_q.ctl.reg_write & CondExE;
    em_d.pc_src    = de_q.ctl.pc_src & CondExE;
  end

  stage_reg_clr #(.W($bits(de_t))) u_de (
    .clk   (clk),
    .reset (reset),
    .clr   (FlushE),
    .d     (de_d),
    .q     (de_q)
  );

  stage_reg_clr #(.W($bits(ew_t))) u_em (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .d     (em_d),
    .q     (em_q)
  );

  stage_reg_clr #(.W($bits(ew_t))) u_mw (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .d     (em_q),
    .q     (mw_q)
  );

  // Compares are not gated by write enables (the hazard unit does that),
  // only by stage occupancy so bubbles stay silent.
  assign Match_1E_M  = de_q.valid & em_q.valid & src_match(de_q.ra1, em_q.wa3);
  assign Match_1E_W  = de_q.valid & mw_q.valid & src_match(de_q.ra1, mw_q.wa3);
  assign Match_2E_M  = de_q.valid & em_q.valid & src_match(de_q.ra2, em_q.wa3);
  assign Match_2E_W  = de_q.valid & mw_q.valid & src_match(de_q.ra2, mw_q.wa3);
  assign Match_12D_E = de_q.valid &
                       (src_match(RA1D, de_q.wa3) | src_match(RA2D, de_q.wa3));

  assign MemtoRegE    = de_q.ctl.mem_to_reg;
  assign RegWriteM    = em_q.reg_write;
  assign RegWriteW    = mw_q.reg_write;
  assign PCWrPendingF = PCSrcD | de_q.ctl.pc_src | em_q.pc_src;
  assign PCSrcW       = mw_q.pc_src;

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Directed testbench for hazard_match_pipe with hand-computed expectations.
module tb_hazard_match_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemtoRegD, PCSrcD, CondExE, FlushE;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic       MemtoRegE, RegWriteM, RegWriteW, PCWrPendingF, PCSrcW;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_match_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .PCSrcD       (PCSrcD),
    .CondExE      (CondExE),
    .FlushE       (FlushE),
    .Match_1E_M   (Match_1E_M),
    .Match_1E_W   (Match_1E_W),
    .Match_2E_M   (Match_2E_M),
    .Match_2E_W   (Match_2E_W),
    .Match_12D_E  (Match_12D_E),
    .MemtoRegE    (MemtoRegE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .PCWrPendingF (PCWrPendingF),
    .PCSrcW       (PCSrcW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] wa3, input logic rw,
                       input logic mr, input logic pcs);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mr; PCSrcD = pcs;
    #1;
  endtask

  // Idle instruction: reads the PC register (never matches), writes r0,
  // which no directed test sources.
  task automatic idle();
    drive(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      idle();
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".m1em"}, Match_1E_M, 1'b0);
    check({tag, ".m1ew"}, Match_1E_W, 1'b0);
    check({tag, ".m2em"}, Match_2E_M, 1'b0);
    check({tag, ".m2ew"}, Match_2E_W, 1'b0);
    check({tag, ".m12de"}, Match_12D_E, 1'b0);
    check({tag, ".mre"}, MemtoRegE, 1'b0);
    check({tag, ".rwm"}, RegWriteM, 1'b0);
    check({tag, ".rww"}, RegWriteW, 1'b0);
    check({tag, ".pcpend"}, PCWrPendingF, 1'b0);
    check({tag, ".pcsw"}, PCSrcW, 1'b0);
  endtask

  initial begin
    reset = 1'b1; FlushE = 1'b0; CondExE = 1'b0;
    idle();

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      FlushE  = 1'($urandom);
      CondExE = 1'($urandom);
      tick();
    end
    reset = 1'b0; FlushE = 1'b0; CondExE = 1'b1;
    idle();
    check_all_zero("reset");

    // EX forward of source 1 from M then W
    drain();
    drive(4'd15, 4'd15, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'd3, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
    check("fwd.d_cmp", Match_12D_E, 1'b1);
    tick();
    check("fwd.m1em", Match_1E_M, 1'b1);
    check("fwd.rwm", RegWriteM, 1'b1);
    check("fwd.m1ew_early", Match_1E_W, 1'b0);
    tick();  // D re-presents D2
    check("fwd.m1ew", Match_1E_W, 1'b1);
    check("fwd.m1em_after", Match_1E_M, 1'b0);
    check("fwd.rww", RegWriteW, 1'b1);

    // Load-use, then flush the load consumer
    drain();
    drive(4'd15, 4'd15, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(4'd15, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    check("lu.m12de", Match_12D_E, 1'b1);
    check("lu.mre", MemtoRegE, 1'b1);
    FlushE = 1'b1;
    #1;
    check("lu.m12de_flushcyc", Match_12D_E, 1'b1);
    tick();
    check("lu.mre_flushed", MemtoRegE, 1'b0);
    check("lu.m12de_bubble", Match_12D_E, 1'b0);
    check("lu.rwm_load", RegWriteM, 1'b1);
    FlushE = 1'b0;

    // Condition fail squashes the write but not the compare
    drain();
    drive(4'd15, 4'd15, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'd2, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
    CondExE = 1'b0;
    tick();
    check("cf.rwm", RegWriteM, 1'b0);
    check("cf.m1em", Match_1E_M, 1'b1);
    CondExE = 1'b1;
    tick();
    check("cf.rww", RegWriteW, 1'b0);
    check("cf.m1ew", Match_1E_W, 1'b1);

    // Unknown condition with no write in E
    drain();
    CondExE = 1'bx;
    tick();
    check("xcond.rwm", RegWriteM, 1'b0);
    CondExE = 1'b1;

    // PC write pending through D, E, M then W
    drain();
    drive(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1);
    check("pc.pend_d", PCWrPendingF, 1'b1);
    tick();
    idle();
    check("pc.pend_e", PCWrPendingF, 1'b1);
    tick();
    check("pc.pend_m", PCWrPendingF, 1'b1);
    check("pc.pcsw_early", PCSrcW, 1'b0);
    tick();
    check("pc.pend_done", PCWrPendingF, 1'b0);
    check("pc.pcsw", PCSrcW, 1'b1);

    // PC register as source never matches
    drain();
    drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
    check("pcsrc.m12de", Match_12D_E, 1'b0);
    tick();
    check("pcsrc.m1em", Match_1E_M, 1'b0);
    check("pcsrc.m2em", Match_2E_M, 1'b0);
    tick();
    check("pcsrc.m1ew", Match_1E_W, 1'b0);
    check("pcsrc.m2ew", Match_2E_W, 1'b0);

    // EX forward of source 2
    drain();
    drive(4'd15, 4'd15, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'd15, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0);
    check("fwd2.m12de", Match_12D_E, 1'b1);
    tick();
    check("fwd2.m2em", Match_2E_M, 1'b1);
    check("fwd2.m1em", Match_1E_M, 1'b0);
    tick();
    check("fwd2.m2ew", Match_2E_W, 1'b1);
    check("fwd2.m2em_after", Match_2E_M, 1'b0);

    // Reset mid-operation squashes all stages
    drain();
    drive(4'd15, 4'd15, 4'd3, 1'b1, 1'b1, 1'b1);
    tick();
    drive(4'd3, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("midrst.pre_m1em", Match_1E_M, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check_all_zero("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
